arbitro_pop: RTL and testbench
==============================

# arbitro_pop

Pop-side arbiter for the two virtual-channel FIFOs (VC0, VC1) feeding `arbitro_mux`. Each cycle it decides which VC FIFO, if any, to pop. It produces the registered select `pop_delay_VCO` that steers `arbitro_mux` one cycle later, and a valid flag aligned with the mux's registered output `mux_arbitro_1`. VC0 has priority, with a bounded burst so VC1 cannot starve. Popping halts under downstream backpressure.

## Interface
- `MAX_VC0_BURST`, default 4: maximum consecutive VC0 grants while VC1 is non-empty. Legal range 1..15.
- `clk`  input  1  sole clock; all state updates on the rising edge.
- `reset_L`  input  1  reset, synchronous, active-low.
- `VC0_empty`  input  1  VC0 FIFO empty flag; must reflect current contents.
- `VC1_empty`  input  1  VC1 FIFO empty flag; must reflect current contents.
- `pause`  input  1  downstream almost-full (OR of destination FIFOs); threshold leaves room for 2 in-flight words.
- `pop_VC0`  output  1  pop strobe to VC0 FIFO (combinational).
- `pop_VC1`  output  1  pop strobe to VC1 FIFO (combinational).
- `pop_delay_VCO`  output  1  registered `pop_VC0`; drives `arbitro_mux` select.
- `valid_arbitro_1`  output  1  registered; high when `mux_arbitro_1` holds a popped word.

## Operation
- Grant decision is evaluated every cycle with `reset_L`=1. `pop_VC0` and `pop_VC1` are never both 1.
- No grant when `pause`=1, or when both FIFOs are empty.
- Otherwise, if `VC0_empty`=0 and not (`burst_cnt`==`MAX_VC0_BURST` and `VC1_empty`=0), then `pop_VC0`=1.
- Otherwise, if `VC1_empty`=0, then `pop_VC1`=1.
- `burst_cnt` is a 4-bit register:
  - A VC0 grant with `VC1_empty`=0 increments it.
  - A VC1 grant clears it.
  - `VC1_empty`=1 clears it, unless the same cycle increments it, which it cannot, since the increment requires VC1 non-empty.
  - It saturates at `MAX_VC0_BURST` and never wraps.
- A FIFO is never popped while its empty flag is 1.
- `pause` gates pops in the same cycle. Words already in flight (at most 2) still complete, and their valid still propagates.
- While `reset_L`=0:
  - `pop_VC0`=`pop_VC1`=0 combinationally.
  - `burst_cnt`, `pop_delay_VCO`, `v1` and `valid_arbitro_1` are cleared at the edge.
- Reset asserted mid-burst discards in-flight valids. The mux is reset in the same cycle, so the data and valid stay consistent.

## Timing
- Cycle t: `pop_VCx`=1, combinational from the current inputs and `burst_cnt`.
- t+1: the FIFO presents the word. `pop_delay_VCO` = `pop_VC0`(t). Internal `v1` = `pop_VC0`(t) | `pop_VC1`(t).
- t+2: `mux_arbitro_1` is registered by `arbitro_mux`. `valid_arbitro_1` = `v1`(t+1).
- Pop-to-valid latency is exactly 2 cycles. Throughput is one word per cycle.
- `pop_delay_VCO` updates every cycle, including no-grant cycles (it becomes 0). The mux output in those cycles is qualified invalid by `valid_arbitro_1`=0.
- Reset values of all registered outputs: 0.
- The reset release edge produces no pop that cycle. The first pop can occur in the first cycle with `reset_L`=1.
- Simultaneous events:
  - `pause` rising in the same cycle as a burst limit: no pop, and `burst_cnt` holds.
  - VC0 going empty exactly as the burst limit is reached: VC1 is granted.

## Structure
- Shared package `arbitro_pkg`: `VC_WIDTH`=6 and `MAX_VC0_BURST_DFLT`=4, also used by `arbitro_mux` and the VC FIFO wrappers.
- Single module with a small grant block and a 2-stage valid pipe.
- Optional sub-module `arbitro_burst_cnt`: the saturating counter with inc/clr/limit compare.

## Test plan
- Reset: `reset_L`=0 for 3 cycles with both FIFOs non-empty → no pops; all registered outputs 0. After release, `pop_VC0`=1 in the first cycle.
- VC0 only: 3 words in VC0, VC1 empty, `pause`=0 → `pop_VC0` high 3 consecutive cycles. `valid_arbitro_1` high 3 cycles starting 2 cycles after the first pop. `pop_delay_VCO`=1 in those cycles.
- Anti-starvation: both FIFOs hold 10 words, `MAX_VC0_BURST`=4 → grant order VC0×4, VC1, VC0×4, VC1…. `burst_cnt` never exceeds 4.
- Backpressure: `pause`=1 for 5 cycles mid-stream → pops stop the same cycle. Exactly the ≤2 in-flight words still show `valid_arbitro_1`. Resume the cycle after `pause` falls.
- Empty boundary: VC0 holds 1 word, VC1 holds 2 → single VC0 pop, then VC1 pops. No pop is ever issued with the corresponding empty flag at 1 (assertion).
- Reset mid-operation: assert `reset_L`=0 one cycle after a pop → `valid_arbitro_1` stays 0 and `burst_cnt`=0. The stream restarts cleanly after release.

Source files
------------

// File: rtl/arbitro_pkg.sv
// arbitro_pkg: shared constants for the arbiter, mux and VC FIFO wrappers
package arbitro_pkg;
  localparam int VC_WIDTH = 6;
  localparam int MAX_VC0_BURST_DFLT = 4;
  localparam int BURST_W = 4;
endpackage

// File: rtl/arbitro_pop_if.sv
// arbitro_pop_if: FIFO status/pop strobes and mux-side select/valid of the pop arbiter
interface arbitro_pop_if;
  logic VC0_empty;
  logic VC1_empty;
  logic pause;
  logic pop_VC0;
  logic pop_VC1;
  logic pop_delay_VCO;
  logic valid_arbitro_1;
  modport master(
    input  VC0_empty, VC1_empty, pause,
    output pop_VC0, pop_VC1, pop_delay_VCO, valid_arbitro_1
  );
  modport slave(
    output VC0_empty, VC1_empty, pause,
    input  pop_VC0, pop_VC1, pop_delay_VCO, valid_arbitro_1
  );
endinterface

// File: rtl/arbitro_burst_cnt.sv
// arbitro_burst_cnt: saturating count of consecutive VC0 grants, flags the burst limit
module arbitro_burst_cnt
  import arbitro_pkg::*;
#(
  parameter int MAX = MAX_VC0_BURST_DFLT
) (
  input  logic clk,
  input  logic reset_L,
  input  logic inc_i,
  input  logic clr_i,
  output logic at_limit_o
);
  localparam logic [BURST_W-1:0] LIM = BURST_W'(MAX);
  logic [BURST_W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = clr_i ? '0 : (inc_i && cnt_q != LIM) ? cnt_q + 1'b1 : cnt_q;
  always_ff @(posedge clk) cnt_q <= !reset_L ? '0 : cnt_d;
  assign at_limit_o = cnt_q == LIM;
endmodule

// File: rtl/arbitro_pop.sv
// arbitro_pop: VC0-priority pop arbiter with bounded VC0 bursts and a 2-stage valid pipe
module arbitro_pop
  import arbitro_pkg::*;
#(
  parameter int MAX_VC0_BURST = MAX_VC0_BURST_DFLT
) (
  input logic clk,
  input logic reset_L,
  arbitro_pop_if.master bus
);
  logic at_limit, go, pop0, pop1;
  logic pop_delay_q, v1_q, valid_q;
  assign go   = reset_L & ~bus.pause;
  // VC0 yields only when its burst limit is hit and VC1 actually has a word waiting
  assign pop0 = go & ~bus.VC0_empty & ~(at_limit & ~bus.VC1_empty);
  assign pop1 = go & ~bus.VC1_empty & ~pop0;
  arbitro_burst_cnt #(.MAX(MAX_VC0_BURST)) u_cnt (
    .clk       (clk),
    .reset_L   (reset_L),
    .inc_i     (pop0 & ~bus.VC1_empty),
    .clr_i     (pop1 | bus.VC1_empty),
    .at_limit_o(at_limit)
  );
  always_ff @(posedge clk) begin
    pop_delay_q <= reset_L & pop0;
    v1_q        <= reset_L & (pop0 | pop1);
    valid_q     <= reset_L & v1_q;
  end
  assign bus.pop_VC0         = pop0;
  assign bus.pop_VC1         = pop1;
  assign bus.pop_delay_VCO   = pop_delay_q;
  assign bus.valid_arbitro_1 = valid_q;
endmodule

// File: tb/tb_arbitro_pop.sv
// tb_arbitro_pop: randomized and directed checks of arbitro_pop against a word-count model
module tb_arbitro_pop;
  localparam int MAX = 4;
  logic clk = 0;
  logic reset_L = 0;
  arbitro_pop_if bus();
  arbitro_pop #(.MAX_VC0_BURST(MAX)) dut (.clk(clk), .reset_L(reset_L), .bus(bus));
  always #5 clk = ~clk;
  int checks = 0, errors = 0;
  int n0 = 0, n1 = 0, m_burst = 0;
  bit m_delay = 0, m_v1 = 0, m_valid = 0;
  logic last0, last1, last_valid;
  logic [9:0] seq;
  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %b want %b at %0t", name, act, exp, $time);
    end
  endtask
  // one clock: drive inputs from FIFO word counts, compare against the model, advance model
  task automatic step(input bit rst_l, input bit pau, input int add0, input int add1);
    bit e0, e1;
    @(posedge clk);
    #1;
    reset_L = rst_l;
    bus.pause = pau;
    bus.VC0_empty = (n0 == 0);
    bus.VC1_empty = (n1 == 0);
    #1;
    e0 = 0;
    e1 = 0;
    if (rst_l && !pau) begin
      if (n0 > 0 && !(m_burst == MAX && n1 > 0)) e0 = 1;
      else if (n1 > 0) e1 = 1;
    end
    chk("pop_VC0", bus.pop_VC0, e0);
    chk("pop_VC1", bus.pop_VC1, e1);
    chk("pop_delay_VCO", bus.pop_delay_VCO, m_delay);
    chk("valid_arbitro_1", bus.valid_arbitro_1, m_valid);
    if ((bus.pop_VC0 && bus.VC0_empty) || (bus.pop_VC1 && bus.VC1_empty) || (bus.pop_VC0 && bus.pop_VC1)) begin
      errors++;
      $display("FAIL pop_legal pop0=%b pop1=%b e0=%b e1=%b", bus.pop_VC0, bus.pop_VC1, bus.VC0_empty, bus.VC1_empty);
    end
    last0 = bus.pop_VC0;
    last1 = bus.pop_VC1;
    last_valid = bus.valid_arbitro_1;
    if (!rst_l) begin
      m_valid = 0;
      m_v1 = 0;
      m_delay = 0;
      m_burst = 0;
    end else begin
      m_valid = m_v1;
      m_v1 = e0 | e1;
      m_delay = e0;
      if (e1 || n1 == 0) m_burst = 0;
      else if (e0 && m_burst < MAX) m_burst++;
    end
    if (m_burst > MAX) begin
      errors++;
      $display("FAIL burst_bound got %0d want <= %0d", m_burst, MAX);
    end
    n0 = n0 - int'(e0) + add0;
    n1 = n1 - int'(e1) + add1;
  endtask
  initial begin
    bus.pause = 0;
    bus.VC0_empty = 1;
    bus.VC1_empty = 1;
    n0 = 10;
    n1 = 10;
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0);
    chk("rst_pop0", last0, 1'b0);
    chk("rst_valid", last_valid, 1'b0);
    chk("rst_delay", bus.pop_delay_VCO, 1'b0);
    for (int i = 0; i < 10; i++) begin
      step(1, 0, 0, 0);
      if (i == 0) chk("first_pop_vc0", last0, 1'b1);
      seq[i] = last1;
    end
    checks++;
    if (seq !== 10'b10_0001_0000) begin
      errors++;
      $display("FAIL grant_order got %b want %b", seq, 10'b10_0001_0000);
    end
    for (int k = 0; k < 5; k++) begin
      step(1, 1, 0, 0);
      chk("pause_no_pop", last0 | last1, 1'b0);
      chk("pause_inflight", last_valid, k < 2);
    end
    step(1, 0, 0, 0);
    chk("resume_pop", last0, 1'b1);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    chk("midrst_valid", last_valid, 1'b0);
    n0 = 1;
    n1 = 2;
    step(1, 0, 0, 0);
    chk("edge_vc0", last0, 1'b1);
    step(1, 0, 0, 0);
    chk("edge_vc1a", last1, 1'b1);
    step(1, 0, 0, 0);
    chk("edge_vc1b", last1, 1'b1);
    step(1, 0, 0, 0);
    chk("edge_idle", last0 | last1, 1'b0);
    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 49) != 0, $urandom_range(0, 4) == 0,
           (n0 < 12 && $urandom_range(0, 2) != 0) ? 1 : 0,
           (n1 < 12 && $urandom_range(0, 3) == 0) ? 1 : 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
